// File: rtl/led_chaser_engine.sv
// One-hot LED chaser driven by a PIO control byte.
// Wrap or bounce motion, either direction, programmable step period.
module led_chaser_engine #(
    parameter int NUM_LEDS = 8,
    parameter int TICK_DIV = 50000,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          ctrl,
    output logic [NUM_LEDS-1:0] leds,
    output logic                step_pulse,
    output logic                running
);

    localparam int PW = $clog2(NUM_LEDS);
    localparam logic [PW-1:0]       POS_LAST = PW'(NUM_LEDS - 1);
    localparam logic [PW-1:0]       POS_PEN  = PW'(NUM_LEDS - 2);
    localparam logic [PW-1:0]       POS_ONE  = PW'(1);
    localparam logic [CNT_W-1:0]    PRE_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]    PRE_ONE  = CNT_W'(1);
    localparam logic [NUM_LEDS-1:0] LED_ONE  = NUM_LEDS'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_t;

    state_t               state, state_d;
    logic [7:0]           ctrl_q;
    logic [PW-1:0]        pos, pos_d, nxt_pos;
    logic                 cur_dir, dir_d, nxt_dir;
    logic [CNT_W-1:0]     prescaler, pre_d;
    logic [4:0]           step_cnt, cnt_d;
    logic [NUM_LEDS-1:0]  leds_d;
    logic                 pulse_d;
    logic                 run_q, dir_q, mode_q, tick;
    logic [4:0]           speed_q;

    assign run_q   = ctrl_q[0];
    assign dir_q   = ctrl_q[1];
    assign mode_q  = ctrl_q[2];
    assign speed_q = ctrl_q[7:3];
    assign tick    = (state == RUN) && (prescaler == PRE_LAST);
    assign running = (state == RUN);

    // Candidate position/direction if a step were taken this cycle.
    always_comb begin
        nxt_pos = pos;
        nxt_dir = cur_dir;
        if (mode_q) begin
            if (!cur_dir) begin
                if (pos == POS_LAST) begin
                    nxt_dir = 1'b1;
                    nxt_pos = POS_PEN;
                end else begin
                    nxt_pos = pos + POS_ONE;
                end
            end else begin
                if (pos == '0) begin
                    nxt_dir = 1'b0;
                    nxt_pos = POS_ONE;
                end else begin
                    nxt_pos = pos - POS_ONE;
                end
            end
        end else begin
            nxt_dir = dir_q;
            if (!dir_q) nxt_pos = (pos == POS_LAST) ? '0 : pos + POS_ONE;
            else        nxt_pos = (pos == '0) ? POS_LAST : pos - POS_ONE;
        end
    end

    always_comb begin
        state_d = state;
        pos_d   = pos;
        dir_d   = cur_dir;
        pre_d   = '0;
        cnt_d   = step_cnt;
        leds_d  = leds;
        pulse_d = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (run_q) begin
                    state_d = RUN;
                    leds_d  = LED_ONE << pos;
                    dir_d   = dir_q;
                end
            end
            RUN: begin
                if (!run_q) begin
                    // Leaving RUN wins over a coincident tick.
                    state_d = PAUSE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (step_cnt >= speed_q) begin
                        cnt_d   = '0;
                        pos_d   = nxt_pos;
                        dir_d   = nxt_dir;
                        leds_d  = LED_ONE << nxt_pos;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = step_cnt + 5'd1;
                    end
                end else begin
                    pre_d = prescaler + PRE_ONE;
                end
            end
            PAUSE: begin
                cnt_d = '0;
                if (run_q) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ctrl_q     <= '0;
            pos        <= '0;
            cur_dir    <= 1'b0;
            prescaler  <= '0;
            step_cnt   <= '0;
            leds       <= '0;
            step_pulse <= 1'b0;
        end else begin
            state      <= state_d;
            ctrl_q     <= ctrl;
            pos        <= pos_d;
            cur_dir    <= dir_d;
            prescaler  <= pre_d;
            step_cnt   <= cnt_d;
            leds       <= leds_d;
            step_pulse <= pulse_d;
        end
    end

endmodule
